reg_writeback_scheduler: RTL and testbench

- Controls the 256x32 register file: owns its single write port and tracks pending writes to gate instruction issue.
- Arbitrates two writeback sources (ALU, memory/load unit) onto `dest`/`write_data`/`write_enable`, round-robin.
- Keeps a per-register busy scoreboard so issue stalls on RAW/WAW hazards against in-flight results.
- Sits between the issue stage, the execution units and the register file, whose same-cycle write-to-read bypass it relies on.

---
 rtl/reg_writeback_scheduler_pkg.sv | 12 +
 rtl/reg_writeback_scheduler_if.sv | 37 +++
 rtl/reg_writeback_scheduler_rr_arbiter2.sv | 33 +++
 rtl/reg_writeback_scheduler.sv | 71 +++++++
 tb/tb_reg_writeback_scheduler.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_scheduler_pkg.sv
// Register-file wide constants and the writeback grant encoding, shared by the
// register file, issue stage and writeback scheduler.
package regfile_pkg;
  localparam int REG_ADDR_W = 8;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 8'd255;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;
endpackage

// File: rtl/reg_writeback_scheduler_if.sv
// Issue / writeback / register-file bundle around the writeback scheduler.
interface reg_writeback_scheduler_if;
  import regfile_pkg::*;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_src1;
  logic [REG_ADDR_W-1:0] issue_src2;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic                  issue_writes;
  logic                  issue_stall;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0]     rf_write_data;
  logic                  rf_write_enable;
  logic [8:0]            pending_count;

  modport master (
    output issue_valid, issue_src1, issue_src2, issue_dest, issue_writes,
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  issue_stall, alu_ready, mem_ready,
    input  rf_dest, rf_write_data, rf_write_enable, pending_count
  );

  modport slave (
    input  issue_valid, issue_src1, issue_src2, issue_dest, issue_writes,
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output issue_stall, alu_ready, mem_ready,
    output rf_dest, rf_write_data, rf_write_enable, pending_count
  );
endinterface

// File: rtl/reg_writeback_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant only moves on real conflicts.
// state     | meaning
// GRANT_ALU | ALU won the last conflict, MEM wins the next one
// GRANT_MEM | MEM won the last conflict (reset), ALU wins the next one
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_req_alu,
  input  logic i_req_mem,
  output logic o_gnt_alu,
  output logic o_gnt_mem
);
  grant_e r_last_grant;
  grant_e w_last_grant_nxt;

  always_ff @(posedge clock) begin
    if (reset) r_last_grant <= GRANT_MEM;
    else       r_last_grant <= w_last_grant_nxt;
  end

  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (i_req_alu && i_req_mem)
      w_last_grant_nxt = (r_last_grant == GRANT_MEM) ? GRANT_ALU : GRANT_MEM;
  end

  always_comb begin
    o_gnt_alu = i_req_alu && (!i_req_mem || r_last_grant == GRANT_MEM);
    o_gnt_mem = i_req_mem && (!i_req_alu || r_last_grant == GRANT_ALU);
  end
endmodule

// File: rtl/reg_writeback_scheduler.sv
// Owns the register-file write port: arbitrates ALU/load writebacks and keeps
// the per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module reg_writeback_scheduler
  import regfile_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  reg_writeback_scheduler_if.slave bus
);
  logic [255:0]          r_busy;
  logic [8:0]            r_pending;
  logic                  w_gnt_alu, w_gnt_mem;
  logic                  w_sel_alu, w_sel_mem;
  logic [REG_ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0]     w_data;
  logic                  w_we;
  logic                  w_haz1, w_haz2, w_hazd;
  logic                  w_stall;
  logic                  w_set, w_clr, w_inc, w_dec;

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .i_req_alu (bus.alu_valid),
    .i_req_mem (bus.mem_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_mem (w_gnt_mem)
  );

  assign w_sel_alu = !reset && w_gnt_alu;
  assign w_sel_mem = !reset && w_gnt_mem;
  assign w_dest    = w_sel_alu ? bus.alu_dest : (w_sel_mem ? bus.mem_dest : '0);
  assign w_data    = w_sel_alu ? bus.alu_data : (w_sel_mem ? bus.mem_data : '0);
  assign w_we      = (w_sel_alu || w_sel_mem) && (w_dest != ZERO_REG);

  // A result landing this cycle is forwarded by the register file, so it clears the hazard.
  assign w_haz1 = (bus.issue_src1 != ZERO_REG) && r_busy[bus.issue_src1]
                  && !(w_we && w_dest == bus.issue_src1);
  assign w_haz2 = (bus.issue_src2 != ZERO_REG) && r_busy[bus.issue_src2]
                  && !(w_we && w_dest == bus.issue_src2);
  assign w_hazd = (bus.issue_dest != ZERO_REG) && r_busy[bus.issue_dest]
                  && !(w_we && w_dest == bus.issue_dest);

  assign w_stall = reset || (bus.issue_valid &&
                   (w_haz1 || w_haz2 || (bus.issue_writes && w_hazd)));

  assign w_set = bus.issue_valid && !w_stall && bus.issue_writes && (bus.issue_dest != ZERO_REG);
  assign w_clr = w_we && r_busy[w_dest];
  // Counting from the old busy bit keeps pending equal to the popcount when set and clear collide.
  assign w_inc = w_set && !r_busy[bus.issue_dest];
  assign w_dec = w_clr && !(w_set && bus.issue_dest == w_dest);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      if (w_clr) r_busy[w_dest] <= 1'b0;
      if (w_set) r_busy[bus.issue_dest] <= 1'b1;
      r_pending <= r_pending + {8'd0, w_inc} - {8'd0, w_dec};
    end
  end

  assign bus.issue_stall     = w_stall;
  assign bus.alu_ready       = w_sel_alu;
  assign bus.mem_ready       = w_sel_mem;
  assign bus.rf_dest         = w_dest;
  assign bus.rf_write_data   = w_data;
  assign bus.rf_write_enable = w_we;
  assign bus.pending_count   = r_pending;
endmodule

// File: tb/tb_reg_writeback_scheduler.sv
// Directed bench: driver pushes expected writebacks, a negedge monitor pops them
// on each transfer; issue_stall/pending_count are checked against hand values.
module tb_reg_writeback_scheduler;
  import regfile_pkg::*;

  logic clock = 1'b0;
  logic reset;
  reg_writeback_scheduler_if bus ();

  reg_writeback_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        from_mem;
    logic        we;
    logic [7:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && ((bus.alu_valid && bus.alu_ready) || (bus.mem_valid && bus.mem_ready))) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_transfer: dest 0x%0h with empty scoreboard", bus.rf_dest);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, !e.from_mem});
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, e.from_mem});
        chk("rf_write_enable", {31'd0, bus.rf_write_enable}, {31'd0, e.we});
        if (e.we) begin
          chk("rf_dest", {24'd0, bus.rf_dest}, {24'd0, e.dest});
          chk("rf_write_data", bus.rf_write_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.issue_valid = 0; bus.issue_src1 = 0; bus.issue_src2 = 0;
    bus.issue_dest = 0; bus.issue_writes = 0;
    bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_dest = 0; bus.mem_data = 0;
  endtask

  task automatic next();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic issue(input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] d, input logic w);
    bus.issue_valid = 1; bus.issue_src1 = s1; bus.issue_src2 = s2;
    bus.issue_dest = d; bus.issue_writes = w;
  endtask

  task automatic alu(input logic [7:0] d, input logic [31:0] v);
    bus.alu_valid = 1; bus.alu_dest = d; bus.alu_data = v;
  endtask

  task automatic mem(input logic [7:0] d, input logic [31:0] v);
    bus.mem_valid = 1; bus.mem_dest = d; bus.mem_data = v;
  endtask

  task automatic expect_wb(input logic m, input logic we, input logic [7:0] d, input logic [31:0] v);
    wb_t e;
    e.from_mem = m; e.we = we; e.dest = d; e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic chk_status(input string tag, input logic stall, input logic [8:0] pend);
    @(negedge clock);
    chk({tag, "_stall"}, {31'd0, bus.issue_stall}, {31'd0, stall});
    chk({tag, "_pending"}, {23'd0, bus.pending_count}, {23'd0, pend});
  endtask

  initial begin
    idle();
    reset = 1;
    next();
    issue(8'd5, 8'd0, 8'd5, 1); alu(8'd1, 32'h11); mem(8'd2, 32'h22);
    @(negedge clock);
    chk("rst_stall", {31'd0, bus.issue_stall}, 32'd1);
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_we", {31'd0, bus.rf_write_enable}, 32'd0);
    next(); reset = 0;
    chk_status("idle", 0, 0);
    chk("idle_rf_dest", {24'd0, bus.rf_dest}, 32'd0);
    chk("idle_rf_data", bus.rf_write_data, 32'd0);

    // Busy set on issue, then RAW/WAW stalls on r5.
    next(); issue(8'd0, 8'd1, 8'd5, 1); chk_status("issue5", 0, 0);
    next(); issue(8'd5, 8'd0, 8'd0, 0); chk_status("raw_src1", 1, 1);
    next(); issue(8'd0, 8'd5, 8'd0, 0); chk_status("raw_src2", 1, 1);
    next(); issue(8'd1, 8'd2, 8'd5, 1); chk_status("waw", 1, 1);
    next(); bus.issue_valid = 0; bus.issue_src1 = 8'd5; chk_status("no_valid", 0, 1);

    // Same-cycle writeback bypasses the hazard.
    next(); issue(8'd5, 8'd0, 8'd0, 0); alu(8'd5, 32'hDEADBEEF);
    expect_wb(0, 1, 8'd5, 32'hDEADBEEF);
    chk_status("bypass", 0, 1);
    next(); chk_status("cleared5", 0, 0);

    // Conflicts alternate starting with ALU.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) next();
      else begin @(posedge clock); #1; end
      alu(8'd3, 32'h0000_0033); mem(8'd4, 32'h0000_0044);
      expect_wb(i[0], 1, i[0] ? 8'd4 : 8'd3, i[0] ? 32'h44 : 32'h33);
    end
    next(); chk_status("after_rr", 0, 0);

    // Zero register never becomes busy and its writes are dropped.
    next(); issue(8'd0, 8'd0, ZERO_REG, 1); chk_status("zero_issue", 0, 0);
    next(); issue(ZERO_REG, ZERO_REG, ZERO_REG, 1); mem(ZERO_REG, 32'hFF);
    expect_wb(1, 0, ZERO_REG, 32'hFF);
    chk_status("zero_wb", 0, 0);

    // Set and clear of r7 in the same cycle: set wins.
    next(); issue(8'd0, 8'd0, 8'd7, 1); chk_status("issue7", 0, 0);
    next(); issue(8'd0, 8'd0, 8'd7, 1); mem(8'd7, 32'h77);
    expect_wb(1, 1, 8'd7, 32'h77);
    chk_status("set_clr7", 0, 1);
    next(); issue(8'd7, 8'd0, 8'd0, 0); chk_status("still7", 1, 1);

    next(); issue(8'd0, 8'd0, 8'd8, 1); chk_status("issue8", 0, 1);
    next(); issue(8'd0, 8'd0, 8'd9, 1); chk_status("issue9", 0, 2);
    next(); chk_status("three_busy", 0, 3);

    // Reset flushes the scoreboard.
    next(); reset = 1; issue(8'd0, 8'd0, 8'd0, 0); alu(8'd20, 32'h20);
    @(negedge clock);
    chk("rst2_stall", {31'd0, bus.issue_stall}, 32'd1);
    chk("rst2_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst2_we", {31'd0, bus.rf_write_enable}, 32'd0);
    next(); reset = 0; chk_status("post_rst", 0, 0);
    next(); issue(8'd7, 8'd8, 8'd9, 1); chk_status("post_rst_issue", 0, 0);
    next(); chk_status("post_rst_busy9", 0, 1);

    next(); next();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
